// File: rtl/top_block_sum.sv
// Sums words 0..6 of each of four 8-word SRAM blocks and writes the 16-bit result to word 7.
// Runs once after reset, then parks in StDone with Ready high.
module top_block_sum (
  input  logic        Clock,
  input  logic        Reset,
  output logic        Ready,
  output logic [4:0]  Address,
  output logic        ReadEnable,
  output logic        WriteEnable,
  output logic [15:0] DataIN,
  input  logic [15:0] DataOut
);

  typedef enum logic [1:0] {StRead, StAcc, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  blk_q, blk_d;
  logic [2:0]  word_q, word_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  addr_q, addr_d;
  logic        ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    word_d  = word_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    unique case (state_q)
      StRead: begin
        state_d = StAcc;
      end
      StAcc: begin
        // DataOut holds the word strobed in the preceding StRead cycle
        acc_d = acc_q + DataOut;
        if (word_q == 3'd6) begin
          state_d = StWrite;
          addr_d  = {blk_q, 3'd7};
        end else begin
          word_d  = word_q + 3'd1;
          state_d = StRead;
          addr_d  = {blk_q, word_d};
        end
      end
      StWrite: begin
        acc_d  = '0;
        word_d = '0;
        if (blk_q == 2'd3) begin
          state_d = StDone;
          ready_d = 1'b1;
        end else begin
          blk_d   = blk_q + 2'd1;
          state_d = StRead;
          addr_d  = {blk_d, 3'd0};
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StRead;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StRead;
      blk_q   <= '0;
      word_q  <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
    end
  end

  // Strobes decode straight from the state register so the first read lands in cycle 1
  // after release; Reset masks every output so no access leaks while it is held.
  always_comb begin
    ReadEnable  = (state_q == StRead) && !Reset;
    WriteEnable = (state_q == StWrite) && !Reset;
    DataIN      = WriteEnable ? acc_q : 16'd0;
    Address     = Reset ? 5'd0 : addr_q;
    Ready       = ready_q && !Reset;
  end

  strobe_exclusive_a: assert property (@(posedge Clock) !(ReadEnable && WriteEnable));

endmodule

// File: tb/tb_top_block_sum.sv
// Directed bench for top_block_sum: behavioural SRAM, per-run access monitor and
// hand-computed block sums for four memory images, including a mid-run reset.
module tb_top_block_sum;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Ready;
  logic [4:0]  Address;
  logic        ReadEnable;
  logic        WriteEnable;
  logic [15:0] DataIN;
  logic [15:0] DataOut;

  logic [15:0] mem      [32];
  logic [15:0] init_mem [32];
  logic        load = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt, wr_cnt, both_cnt, bad_waddr;

  top_block_sum dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Ready      (Ready),
    .Address    (Address),
    .ReadEnable (ReadEnable),
    .WriteEnable(WriteEnable),
    .DataIN     (DataIN),
    .DataOut    (DataOut)
  );

  always #5 Clock = ~Clock;

  // Registered-read SRAM; a read wins when both strobes are high.
  always @(posedge Clock) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
    end else if (ReadEnable) begin
      DataOut <= mem[Address];
    end else if (WriteEnable) begin
      mem[Address] <= DataIN;
    end
  end

  always @(posedge Clock) begin
    if (Reset) begin
      rd_cnt    <= 0;
      wr_cnt    <= 0;
      both_cnt  <= 0;
      bad_waddr <= 0;
    end else begin
      if (ReadEnable && WriteEnable) both_cnt <= both_cnt + 1;
      if (ReadEnable) rd_cnt <= rd_cnt + 1;
      if (WriteEnable) begin
        if ({27'd0, Address} != 32'(wr_cnt * 8 + 7)) bad_waddr <= bad_waddr + 1;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // mode 0: all 0x0001; mode 1: word = address; mode 2: mode 1 with block 0 inputs 0xFFFF
  task automatic set_image(input int mode);
    for (int i = 0; i < 32; i++) begin
      if (i % 8 == 7) init_mem[i] = 16'h5A5A;
      else if (mode == 0) init_mem[i] = 16'h0001;
      else if (mode == 2 && i < 8) init_mem[i] = 16'hFFFF;
      else init_mem[i] = 16'(i);
    end
    if (mode == 0) for (int b = 0; b < 4; b++) init_mem[b * 8 + 7] = 16'h0001;
  endtask

  task automatic run(input string name, input int pulse_at,
                     input logic [15:0] r0, input logic [15:0] r1,
                     input logic [15:0] r2, input logic [15:0] r3);
    int rise;
    int diffs;
    bit pulsed;
    rise   = 0;
    pulsed = 0;
    Reset  = 1'b1;
    load   = 1'b1;
    @(posedge Clock); #1;
    load = 1'b0;
    @(posedge Clock); #1;
    check({name, ":rst_out"}, {8'd0, Ready, ReadEnable, WriteEnable, Address, DataIN}, 32'd0);
    Reset = 1'b0;
    for (int c = 1; c <= 100 && rise == 0; c++) begin
      @(negedge Clock);
      if (c == 1) check({name, ":first_read"}, {ReadEnable, WriteEnable, Address}, {2'b10, 5'd0});
      if (Ready) rise = c;
      @(posedge Clock); #1;
      if (pulse_at != 0 && !pulsed && c == pulse_at - 1) begin
        Reset = 1'b1;
        @(negedge Clock);
        check({name, ":rst_gate"}, {ReadEnable, WriteEnable, Ready}, 3'b000);
        @(posedge Clock); #1;
        Reset  = 1'b0;
        pulsed = 1;
        c      = 0;
      end
    end
    check({name, ":ready_cycle"}, rise, 61);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check({name, ":done_hold"}, {8'd0, Ready, ReadEnable, WriteEnable, Address, DataIN},
          {8'd0, 1'b1, 1'b0, 1'b0, 5'd31, 16'd0});
    check({name, ":reads"}, rd_cnt, 28);
    check({name, ":writes"}, wr_cnt, 4);
    check({name, ":both_strobes"}, both_cnt, 0);
    check({name, ":write_order"}, bad_waddr, 0);
    check({name, ":mem7"}, mem[7], r0);
    check({name, ":mem15"}, mem[15], r1);
    check({name, ":mem23"}, mem[23], r2);
    check({name, ":mem31"}, mem[31], r3);
    diffs = 0;
    for (int i = 0; i < 32; i++) if (i % 8 != 7 && mem[i] !== init_mem[i]) diffs++;
    check({name, ":inputs_kept"}, diffs, 0);
  endtask

  initial begin
    set_image(0);
    run("ones", 0, 16'd7, 16'd7, 16'd7, 16'd7);
    set_image(1);
    run("ramp", 0, 16'd21, 16'd77, 16'd133, 16'd189);
    set_image(2);
    run("wrap", 0, 16'hFFF9, 16'd77, 16'd133, 16'd189);
    set_image(1);
    run("pulse", 20, 16'd21, 16'd77, 16'd133, 16'd189);
    // Previous run ended in DONE; this reset must clear Ready and redo the whole pass.
    set_image(0);
    run("redo", 0, 16'd7, 16'd7, 16'd7, 16'd7);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/top_block_sum.md
TOP_BLOCK_SUM -- requirements
Module: top_block_sum

Interface
REQ-001 The block SHALL have no parameters; memory depth 32, word width 16, block size 8 are fixed.
REQ-002 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 Ready  output  1  high when all four blocks are processed; held until next reset.
REQ-005 Address  output  5  SRAM word address for the current read or write.
REQ-006 ReadEnable  output  1  SRAM read strobe, one cycle per word read.
REQ-007 WriteEnable  output  1  SRAM write strobe, one cycle per result write.
REQ-008 DataIN  output  16  write data driven to the SRAM.
REQ-009 DataOut  input  16  read data from the SRAM.

Function
REQ-010 The SRAM is external with a registered read: ReadEnable=1 at edge N puts mem[Address] on DataOut after edge N, valid for the whole following cycle.
REQ-011 The SRAM write: WriteEnable=1 at edge N stores DataIN into mem[Address]; if both strobes are high the SRAM performs the read only.
REQ-012 Memory is four blocks b=0..3 of 8 words: inputs at b*8+0..b*8+6, result at b*8+7 (addresses 7, 15, 23, 31).
REQ-013 For each block the block SHALL write mem[b*8+7] = sum of mem[b*8+0..b*8+6], modulo 2^16 (unsigned, carries discarded).
REQ-014 FSM states: READ, ACC, WRITE, DONE.
REQ-015 READ: ReadEnable=1, Address=b*8+k; next state ACC.
REQ-016 ACC: acc <= acc + DataOut; k<6 -> k+1, READ; k=6 -> WRITE.
REQ-017 WRITE: WriteEnable=1, Address=b*8+7, DataIN=acc; then acc<=0, k<=0; b<3 -> b+1, READ; b=3 -> DONE.
REQ-018 DONE: Ready=1, both strobes 0; remains in DONE until Reset.
REQ-019 Processing starts automatically in the first cycle after Reset deasserts; there is no start input.
REQ-020 Timing: 15 cycles per block (7 x READ+ACC, 1 WRITE), 60 cycles total; Ready rises in cycle 61 after Reset release.
REQ-021 ReadEnable and WriteEnable SHALL never be high in the same cycle.
REQ-022 Ready SHALL be 0 in every cycle before DONE.
REQ-023 Address in ACC and DONE states SHALL hold its last driven value; DataIN outside WRITE SHALL be 0.
REQ-024 Only addresses b*8+7 are ever written; input words are never modified.

Reset
REQ-025 Reset=1 at a rising edge: state<=READ, b<=0, k<=0, acc<=0, Ready<=0, ReadEnable<=0, WriteEnable<=0, Address<=0, DataIN<=0.
REQ-026 While Reset=1 no SRAM access occurs; all outputs stay at reset values.
REQ-027 Reset asserted mid-operation aborts immediately; after release processing restarts at block 0, word 0; results already written remain and are recomputed identically.
REQ-028 Reset asserted in DONE clears Ready and restarts the full run.

Verification
REQ-029 All 32 words = 0x0001 -> mem[7]=mem[15]=mem[23]=mem[31]=7; Ready high in cycle 61 after Reset release.
REQ-030 Block b inputs = b*8+k (k=0..6) -> mem[7]=21, mem[15]=77, mem[23]=133, mem[31]=189.
REQ-031 Block 0 inputs all 0xFFFF -> mem[7]=0xFFF9 (wrap); other blocks unaffected.
REQ-032 Reset pulsed for 1 cycle at cycle 20 of the run -> restart at Address 0; final results equal an uninterrupted run; Ready low until 60 cycles after the pulse.
REQ-033 Monitor every cycle: never ReadEnable & WriteEnable both 1; exactly 28 reads and 4 writes per run; write addresses exactly 7, 15, 23, 31 in order.
